update_sequencer: RTL

Initiator side of the particle update handshake. On a frame start it walks particle indices 0..N-1. For each index it:
- reads that particle's accumulator word (force_x, force_y, density_reciprocal) from the accumulator RAM,
- presents the word and the index to the particle updater,
- pulses trigger_update,
- waits for update_finished before moving to the next index.

It sits between the force/density accumulation stage and the particle updater, and reports frame completion to the top-level frame controller.

---
 rtl/update_sequencer_if.sv | 26 ++
 rtl/update_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/update_sequencer_if.sv
// Accumulator RAM read port plus the particle-updater start/finish handshake.
// master = sequencer side, slave = RAM/updater side.
interface update_sequencer_if #(
  parameter int PARTICLE_COUNTER_SIZE = 2,
  parameter int DIMS = 2
);
  localparam int ACC_W = 16 * (DIMS + 1);

  logic [PARTICLE_COUNTER_SIZE-1:0] acc_addr;
  logic                             acc_rd_en;
  logic [ACC_W-1:0]                 acc_data_in;
  logic [ACC_W-1:0]                 accumulator_out;
  logic [PARTICLE_COUNTER_SIZE-1:0] particle_idx;
  logic                             trigger_update;
  logic                             update_finished;

  modport master (
    output acc_addr, acc_rd_en, accumulator_out, particle_idx, trigger_update,
    input  acc_data_in, update_finished
  );

  modport slave (
    input  acc_addr, acc_rd_en, accumulator_out, particle_idx, trigger_update,
    output acc_data_in, update_finished
  );
endinterface

// File: rtl/update_sequencer.sv
// Walks particles 0..count-1 per frame: fetch accumulator word, hand it to the updater, await completion.
// Optional per-particle watchdog is enabled by defining UPDATE_SEQUENCER_TIMEOUT_EN.
module update_sequencer #(
  parameter int PARTICLE_COUNTER_SIZE = 2,
  parameter int DIMS = 2,
  parameter int ACC_READ_LATENCY = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk_in,
  input  logic                             rst,
  input  logic                             frame_start,
  input  logic [PARTICLE_COUNTER_SIZE:0]   particle_count,
  output logic                             busy,
  output logic                             frame_done,
  output logic                             timeout_err,
  update_sequencer_if.master               upd
);
  localparam int ACC_W = 16 * (DIMS + 1);
  localparam logic [PARTICLE_COUNTER_SIZE:0] FULL_COUNT = {1'b1, {PARTICLE_COUNTER_SIZE{1'b0}}};
  localparam logic [1:0] LAT_LAST = 2'(ACC_READ_LATENCY);

  if (ACC_READ_LATENCY < 1 || ACC_READ_LATENCY > 3) begin : g_bad_latency
    $error("ACC_READ_LATENCY must be in 1..3");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, READ_ACC, WAIT_ACC, TRIGGER, WAIT_DONE, ADVANCE, DONE} state_t;

  state_t                           state_reg;
  logic [PARTICLE_COUNTER_SIZE:0]   count_reg;
  logic [PARTICLE_COUNTER_SIZE-1:0] idx_reg;
  logic [PARTICLE_COUNTER_SIZE-1:0] acc_addr_reg;
  logic [PARTICLE_COUNTER_SIZE-1:0] particle_idx_reg;
  logic [1:0]                       lat_cnt_reg;
  logic                             busy_reg;
  logic                             frame_done_reg;
  logic                             acc_rd_en_reg;
  logic                             trigger_reg;
  logic [ACC_W-1:0]                 acc_out_reg;
  logic                             last_particle;

  assign last_particle = ({1'b0, idx_reg} == count_reg - 1'b1);

`ifdef UPDATE_SEQUENCER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt_reg;
  logic            timeout_err_reg;
  assign timeout_err = timeout_err_reg;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_reg        <= IDLE;
      count_reg        <= '0;
      idx_reg          <= '0;
      acc_addr_reg     <= '0;
      particle_idx_reg <= '0;
      lat_cnt_reg      <= '0;
      busy_reg         <= 1'b0;
      frame_done_reg   <= 1'b0;
      acc_rd_en_reg    <= 1'b0;
      trigger_reg      <= 1'b0;
      acc_out_reg      <= '0;
`ifdef UPDATE_SEQUENCER_TIMEOUT_EN
      wd_cnt_reg       <= '0;
      timeout_err_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          frame_done_reg <= 1'b0;
          busy_reg       <= 1'b0;
          // The frame_done cycle still reports busy, so a start landing there is dropped.
          if (frame_start && !busy_reg) begin
            busy_reg  <= 1'b1;
            idx_reg   <= '0;
            count_reg <= (particle_count > FULL_COUNT) ? FULL_COUNT : particle_count;
            state_reg <= (particle_count == '0) ? DONE : READ_ACC;
          end
        end
        READ_ACC: begin
          acc_addr_reg  <= idx_reg;
          acc_rd_en_reg <= 1'b1;
          lat_cnt_reg   <= '0;
          state_reg     <= WAIT_ACC;
        end
        WAIT_ACC: begin
          acc_rd_en_reg <= 1'b0;
          lat_cnt_reg   <= lat_cnt_reg + 2'd1;
          if (lat_cnt_reg == LAT_LAST) begin
            acc_out_reg      <= upd.acc_data_in;
            particle_idx_reg <= idx_reg;
            state_reg        <= TRIGGER;
          end
        end
        TRIGGER: begin
          trigger_reg <= 1'b1;
          state_reg   <= WAIT_DONE;
`ifdef UPDATE_SEQUENCER_TIMEOUT_EN
          wd_cnt_reg  <= '0;
`endif
        end
        WAIT_DONE: begin
          trigger_reg <= 1'b0;
          // A finish alongside our own trigger pulse cannot belong to this particle.
          if (upd.update_finished && !trigger_reg) begin
            state_reg <= ADVANCE;
          end
`ifdef UPDATE_SEQUENCER_TIMEOUT_EN
          else if (wd_cnt_reg == WD_LAST) begin
            timeout_err_reg <= 1'b1;
            state_reg       <= ADVANCE;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
          end
`endif
        end
        ADVANCE: begin
          if (last_particle) begin
            state_reg <= DONE;
          end else begin
            idx_reg   <= idx_reg + 1'b1;
            state_reg <= READ_ACC;
          end
        end
        DONE: begin
          frame_done_reg <= 1'b1;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy                = busy_reg;
  assign frame_done          = frame_done_reg;
  assign upd.acc_addr        = acc_addr_reg;
  assign upd.acc_rd_en       = acc_rd_en_reg;
  assign upd.accumulator_out = acc_out_reg;
  assign upd.particle_idx    = particle_idx_reg;
  assign upd.trigger_update  = trigger_reg;
endmodule
